pwr_backup_ctrl: RTL and testbench



---
 rtl/pwr_backup_ctrl_pkg.sv | 39 +++
 rtl/pwr_backup_ctrl_if.sv | 49 ++++
 rtl/pwr_backup_ctrl_idx_scanner.sv | 59 +++++
 rtl/pwr_backup_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_pwr_backup_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwr_backup_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwr_pkg
// Description : Shared definitions for the power backup controller: FSM state
//               encoding, save/sleep mode encoding, default geometry constants
//               and a small state-classification helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pwr_pkg;

    localparam int c_NREG    = 53;
    localparam int c_W       = 32;
    localparam int c_IDX_LEN = 6;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_HALT  = 4'd1,
        ST_SCAN  = 4'd2,
        ST_SAVE  = 4'd3,
        ST_CLEAR = 4'd4,
        ST_SLEEP = 4'd5,
        ST_RSCAN = 4'd6,
        ST_LOAD  = 4'd7,
        ST_WRITE = 4'd8
    } pwr_state_t;

    typedef enum logic {
        MODE_SBY = 1'b0,
        MODE_OFF = 1'b1
    } pwr_mode_t;

    // States in which an incoming wake pulse must be remembered until the
    // save sweep has finished.
    function automatic logic is_save_phase(input pwr_state_t s);
        return s inside {ST_HALT, ST_SCAN, ST_SAVE, ST_CLEAR};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwr_backup_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pwr_backup_if
// Description : Bundle of the core backup/restore port and the NV memory port.
//               master = controller side, slave = core + NV memory side.
//   dirty_vals   : per reg i, bit 2i dirty, bit 2i+1 written since reset
//   backup_Vouts : current register values, W bits per register
//   backup_acks  : reg i has cleared its dirty flag
//   backup_ens   : one-hot dirty-clear request
//   restore_ens  : one-hot register load strobe
//   restore_Vins : restore data, only the selected slice non-zero
//   nv_*         : NV word address/data, write/read request, read data, ack
// Revision    : 1.0 - initial release
// ============================================================================
interface pwr_backup_if
    import pwr_pkg::*;
#(
    parameter int NREG    = c_NREG,
    parameter int W       = c_W,
    parameter int IDX_LEN = c_IDX_LEN
) ();

    logic [2*NREG-1:0]  dirty_vals;
    logic [W*NREG-1:0]  backup_Vouts;
    logic [NREG-1:0]    backup_acks;
    logic [NREG-1:0]    backup_ens;
    logic [NREG-1:0]    restore_ens;
    logic [W*NREG-1:0]  restore_Vins;
    logic [IDX_LEN-1:0] nv_addr;
    logic [W-1:0]       nv_wdata;
    logic               nv_we;
    logic               nv_re;
    logic [W-1:0]       nv_rdata;
    logic               nv_ack;

    modport master (
        input  dirty_vals, backup_Vouts, backup_acks, nv_rdata, nv_ack,
        output backup_ens, restore_ens, restore_Vins,
               nv_addr, nv_wdata, nv_we, nv_re
    );

    modport slave (
        output dirty_vals, backup_Vouts, backup_acks, nv_rdata, nv_ack,
        input  backup_ens, restore_ens, restore_Vins,
               nv_addr, nv_wdata, nv_we, nv_re
    );

endinterface
`default_nettype wire

// File: rtl/pwr_backup_ctrl_idx_scanner.sv
`default_nettype none
// ============================================================================
// Module      : pwr_idx_scanner
// Description : Register-index walker shared by the save and restore sweeps.
//   Clk, Rst : clock, synchronous active-low reset
//   i_clr    : return index to 0 (wins over i_inc)
//   i_inc    : advance to the next index
//   i_sel    : per-register "needs service" flags for the current sweep
//   o_idx    : current index
//   o_hit    : i_sel bit at the current index
//   o_last   : current index is the final register
// Revision    : 1.0 - initial release
// ============================================================================
module pwr_idx_scanner
    import pwr_pkg::*;
#(
    parameter int NREG    = c_NREG,
    parameter int IDX_LEN = c_IDX_LEN
) (
    input  wire logic               Clk,
    input  wire logic               Rst,
    input  wire logic               i_clr,
    input  wire logic               i_inc,
    input  wire logic [NREG-1:0]    i_sel,
    output logic      [IDX_LEN-1:0] o_idx,
    output logic                    o_hit,
    output logic                    o_last
);

    localparam logic [IDX_LEN-1:0] c_LAST = IDX_LEN'(NREG - 1);

    logic [IDX_LEN-1:0] r_idx;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_idx <= '0;
        end else if (i_clr) begin
            r_idx <= '0;
        end else if (i_inc) begin
            r_idx <= r_idx + IDX_LEN'(1);
        end
    end

    // Decoded compare instead of a variable bit-select keeps the lookup safe
    // for index codes above NREG-1.
    always_comb begin
        o_hit = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (r_idx == IDX_LEN'(i)) begin
                o_hit = i_sel[i];
            end
        end
    end

    assign o_idx  = r_idx;
    assign o_last = (r_idx == c_LAST);

endmodule
`default_nettype wire

// File: rtl/pwr_backup_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pwr_backup_ctrl
// Description : Power-management controller. On stand-by/power-off it halts
//               the core, copies every dirty register into NV memory and
//               clears its dirty flag; after a power-off wake it reloads all
//               registers holding a valid NV copy, then releases the core.
//   Clk, Rst  : clock, synchronous active-low reset
//   stand_by  : level request, save and keep power on
//   Pwr_off   : level request, save then gate power (wins over stand_by)
//   wake      : single-cycle resume pulse
//   bus       : core backup/restore port and NV memory port (master)
//   core_halt : freeze core pipeline
//   pwr_gate  : cut core supply
//   busy      : FSM not in IDLE/SLEEP
// Revision    : 1.0 - initial release
// ============================================================================
module pwr_backup_ctrl
    import pwr_pkg::*;
#(
    parameter int NREG    = c_NREG,
    parameter int W       = c_W,
    parameter int IDX_LEN = c_IDX_LEN
) (
    input  wire logic     Clk,
    input  wire logic     Rst,
    input  wire logic     stand_by,
    input  wire logic     Pwr_off,
    input  wire logic     wake,
    pwr_backup_if.master  bus,
    output logic          core_halt,
    output logic          pwr_gate,
    output logic          busy
);

    pwr_state_t         r_state;
    pwr_state_t         w_next_state;
    pwr_state_t         w_wake_target;
    pwr_mode_t          r_mode;
    logic               r_wake_pend;
    logic [NREG-1:0]    r_nv_valid;
    logic [W-1:0]       r_data;

    logic [NREG-1:0]    w_dirty;
    logic [NREG-1:0]    w_written_unused;
    logic [NREG-1:0]    w_sel;
    logic [IDX_LEN-1:0] w_idx;
    logic               w_hit;
    logic               w_last;
    logic               w_idx_clr;
    logic               w_idx_inc;
    logic               w_wake_now;
    logic [W-1:0]       w_cur_val;
    logic               w_cur_ack;

    logic [NREG-1:0]    w_backup_ens;
    logic [NREG-1:0]    w_restore_ens;
    logic [W*NREG-1:0]  w_restore_vins;

    // Only the "dirty since last backup" half of each flag pair matters here.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_dirty
        assign w_dirty[gi]          = bus.dirty_vals[2*gi];
        assign w_written_unused[gi] = bus.dirty_vals[2*gi+1];
    end

    assign w_sel = (r_state == ST_RSCAN) ? r_nv_valid : w_dirty;

    pwr_idx_scanner #(
        .NREG    (NREG),
        .IDX_LEN (IDX_LEN)
    ) u_scanner (
        .Clk    (Clk),
        .Rst    (Rst),
        .i_clr  (w_idx_clr),
        .i_inc  (w_idx_inc),
        .i_sel  (w_sel),
        .o_idx  (w_idx),
        .o_hit  (w_hit),
        .o_last (w_last)
    );

    // Current-index views of the wide core vectors.
    always_comb begin
        w_cur_val = '0;
        w_cur_ack = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (w_idx == IDX_LEN'(i)) begin
                w_cur_val = bus.backup_Vouts[i*W +: W];
                w_cur_ack = bus.backup_acks[i];
            end
        end
    end

    // A wake that arrives during the save sweep skips SLEEP entirely so the
    // supply is never gated for a single cycle.
    assign w_wake_now    = wake | r_wake_pend;
    assign w_wake_target = (r_mode == MODE_OFF) ? ST_RSCAN : ST_IDLE;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_state     <= ST_IDLE;
            r_mode      <= MODE_SBY;
            r_wake_pend <= 1'b0;
            r_nv_valid  <= '0;
            r_data      <= '0;
        end else begin
            r_state <= w_next_state;

            if (r_state == ST_IDLE && w_next_state == ST_HALT) begin
                r_mode <= Pwr_off ? MODE_OFF : MODE_SBY;
            end

            if (is_save_phase(r_state) && is_save_phase(w_next_state)) begin
                r_wake_pend <= r_wake_pend | wake;
            end else begin
                r_wake_pend <= 1'b0;
            end

            if (r_state == ST_SCAN && w_hit) begin
                r_data <= w_cur_val;
            end else if (r_state == ST_LOAD && bus.nv_ack) begin
                r_data <= bus.nv_rdata;
            end

            if (r_state == ST_SAVE && bus.nv_ack) begin
                for (int i = 0; i < NREG; i++) begin
                    if (w_idx == IDX_LEN'(i)) begin
                        r_nv_valid[i] <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_idx_clr     = 1'b0;
        w_idx_inc     = 1'b0;
        core_halt     = (r_state != ST_IDLE);
        pwr_gate      = (r_state == ST_SLEEP) && (r_mode == MODE_OFF);
        busy          = (r_state != ST_IDLE) && (r_state != ST_SLEEP);
        bus.nv_we     = (r_state == ST_SAVE);
        bus.nv_re     = (r_state == ST_LOAD);
        bus.nv_addr   = (r_state == ST_SAVE || r_state == ST_LOAD) ? w_idx : '0;
        bus.nv_wdata  = (r_state == ST_SAVE) ? r_data : '0;

        case (r_state)
            ST_IDLE: begin
                if (Pwr_off || stand_by) begin
                    w_next_state = ST_HALT;
                end
            end
            ST_HALT: begin
                w_idx_clr    = 1'b1;
                w_next_state = ST_SCAN;
            end
            ST_SCAN: begin
                if (w_hit) begin
                    w_next_state = ST_SAVE;
                end else if (w_last) begin
                    w_idx_clr    = 1'b1;
                    w_next_state = w_wake_now ? w_wake_target : ST_SLEEP;
                end else begin
                    w_idx_inc = 1'b1;
                end
            end
            ST_SAVE: begin
                if (bus.nv_ack) begin
                    w_next_state = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (w_cur_ack) begin
                    if (w_last) begin
                        w_idx_clr    = 1'b1;
                        w_next_state = w_wake_now ? w_wake_target : ST_SLEEP;
                    end else begin
                        w_idx_inc    = 1'b1;
                        w_next_state = ST_SCAN;
                    end
                end
            end
            ST_SLEEP: begin
                if (w_wake_now) begin
                    w_idx_clr    = 1'b1;
                    w_next_state = w_wake_target;
                end
            end
            ST_RSCAN: begin
                if (w_hit) begin
                    w_next_state = ST_LOAD;
                end else if (w_last) begin
                    w_idx_clr    = 1'b1;
                    w_next_state = ST_IDLE;
                end else begin
                    w_idx_inc = 1'b1;
                end
            end
            ST_LOAD: begin
                if (bus.nv_ack) begin
                    w_next_state = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (w_last) begin
                    w_idx_clr    = 1'b1;
                    w_next_state = ST_IDLE;
                end else begin
                    w_idx_inc    = 1'b1;
                    w_next_state = ST_RSCAN;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // One-hot strobes and the sliced restore bus.
    always_comb begin
        w_backup_ens   = '0;
        w_restore_ens  = '0;
        w_restore_vins = '0;
        for (int i = 0; i < NREG; i++) begin
            if (w_idx == IDX_LEN'(i)) begin
                w_backup_ens[i]  = (r_state == ST_CLEAR);
                w_restore_ens[i] = (r_state == ST_WRITE);
                if (r_state == ST_WRITE) begin
                    w_restore_vins[i*W +: W] = r_data;
                end
            end
        end
    end

    assign bus.backup_ens   = w_backup_ens;
    assign bus.restore_ens  = w_restore_ens;
    assign bus.restore_Vins = w_restore_vins;

endmodule
`default_nettype wire

// File: tb/tb_pwr_backup_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwr_backup_ctrl
// Description : Directed self-checking bench for pwr_backup_ctrl with a
//               delay-programmable NV memory model and a core ack model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwr_backup_ctrl;
    import pwr_pkg::*;

    localparam int NREG    = 53;
    localparam int W       = 32;
    localparam int IDX_LEN = 6;

    localparam int          EXP_IDX [3] = '{0, 17, 52};
    localparam logic [31:0] EXP_VAL [3] = '{32'hDEADBEEF, 32'h00000011, 32'hFFFFFFFF};

    logic Clk = 1'b0;
    logic Rst, stand_by, Pwr_off, wake;
    logic core_halt, pwr_gate, busy;

    always #5 Clk = ~Clk;

    pwr_backup_if #(.NREG(NREG), .W(W), .IDX_LEN(IDX_LEN)) bus ();

    pwr_backup_ctrl #(.NREG(NREG), .W(W), .IDX_LEN(IDX_LEN)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .stand_by  (stand_by),
        .Pwr_off   (Pwr_off),
        .wake      (wake),
        .bus       (bus),
        .core_halt (core_halt),
        .pwr_gate  (pwr_gate),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    int          wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    int          bens_q    [$];
    int          rst_idx_q [$];
    logic [31:0] rst_data_q[$];

    int viol_both   = 0;
    int viol_onehot = 0;
    int viol_slice  = 0;
    int unstable    = 0;
    int gate_cycles = 0;

    // ---------------- NV memory model: ack nv_dly cycles after request -----
    logic [31:0] nv_mem [0:63];
    int          nv_dly = 1;
    int          nv_cnt = 0;
    logic [5:0]  h_addr;
    logic [31:0] h_data;

    always @(negedge Clk) begin
        logic was_ack;
        was_ack    = bus.nv_ack;
        bus.nv_ack = 1'b0;
        if (!(bus.nv_we || bus.nv_re)) begin
            nv_cnt = 0;
        end else if (was_ack !== 1'b1) begin
            if (nv_cnt == 0) begin
                h_addr = bus.nv_addr;
                h_data = bus.nv_wdata;
            end else if (bus.nv_addr !== h_addr || (bus.nv_we && bus.nv_wdata !== h_data)) begin
                unstable++;
            end
            if (nv_cnt >= nv_dly) begin
                bus.nv_ack = 1'b1;
                nv_cnt     = 0;
                if (bus.nv_we) begin
                    nv_mem[bus.nv_addr] = bus.nv_wdata;
                    wr_addr_q.push_back(int'(bus.nv_addr));
                    wr_data_q.push_back(bus.nv_wdata);
                end else begin
                    bus.nv_rdata = nv_mem[bus.nv_addr];
                end
            end else begin
                nv_cnt++;
            end
        end
    end

    // ---------------- core model: ack one cycle after backup_ens ----------
    logic [NREG-1:0] prev_ens = '0;
    always @(negedge Clk) begin
        bus.backup_acks = prev_ens;
        prev_ens        = bus.backup_ens;
    end

    // ---------------- monitor ----------------------------------------------
    logic [NREG-1:0] prev_bens = '0;
    always @(negedge Clk) begin
        if (bus.nv_we && bus.nv_re) viol_both++;
        if ($countones(bus.backup_ens) > 1 || $countones(bus.restore_ens) > 1) viol_onehot++;
        if (pwr_gate) gate_cycles++;
        for (int i = 0; i < NREG; i++) begin
            if (bus.backup_ens[i] && !prev_bens[i]) bens_q.push_back(i);
            if (bus.restore_ens[i]) begin
                rst_idx_q.push_back(i);
                rst_data_q.push_back(bus.restore_Vins[i*W +: W]);
            end else if (bus.restore_Vins[i*W +: W] != '0) begin
                viol_slice++;
            end
        end
        prev_bens = bus.backup_ens;
    end

    // ---------------- helpers ----------------------------------------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge Clk);
        #1;
    endtask

    // kind 0: pwr_gate high, 1: core_halt low, 2: NV write of register 17
    task automatic wait_cond(input int kind, input int budget, input string tag);
        bit hit = 1'b0;
        for (int n = 0; n < budget && !hit; n++) begin
            tick();
            case (kind)
                0:       hit = (pwr_gate === 1'b1);
                1:       hit = (core_halt === 1'b0);
                default: hit = (bus.nv_we === 1'b1) && (bus.nv_addr === 6'd17);
            endcase
        end
        chk({tag, "_reached"}, {31'b0, hit}, 32'd1);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_core_halt"}, {31'b0, core_halt}, 32'd0);
        chk({tag, "_pwr_gate"},  {31'b0, pwr_gate},  32'd0);
        chk({tag, "_busy"},      {31'b0, busy},      32'd0);
        chk({tag, "_nv_we"},     {31'b0, bus.nv_we}, 32'd0);
        chk({tag, "_nv_re"},     {31'b0, bus.nv_re}, 32'd0);
        chk({tag, "_backup_ens"},  {31'b0, |bus.backup_ens},   32'd0);
        chk({tag, "_restore_ens"}, {31'b0, |bus.restore_ens},  32'd0);
        chk({tag, "_restore_vin"}, {31'b0, |bus.restore_Vins}, 32'd0);
        chk({tag, "_nv_addr"},  {26'b0, bus.nv_addr}, 32'd0);
        chk({tag, "_nv_wdata"}, bus.nv_wdata,         32'd0);
    endtask

    task automatic check_saves(input int wb, input int bb, input string tag);
        logic [31:0] a, d, e;
        chk({tag, "_wr_count"},   32'(wr_addr_q.size() - wb), 32'd3);
        chk({tag, "_bens_count"}, 32'(bens_q.size() - bb),    32'd3);
        for (int k = 0; k < 3; k++) begin
            a = (wb + k < wr_addr_q.size()) ? 32'(wr_addr_q[wb + k]) : 'x;
            d = (wb + k < wr_data_q.size()) ? wr_data_q[wb + k] : 'x;
            e = (bb + k < bens_q.size()) ? 32'(bens_q[bb + k]) : 'x;
            chk({tag, "_wr_addr"}, a, 32'(EXP_IDX[k]));
            chk({tag, "_wr_data"}, d, EXP_VAL[k]);
            chk({tag, "_bens_idx"}, e, 32'(EXP_IDX[k]));
        end
    endtask

    task automatic check_restores(input int rb, input string tag);
        logic [31:0] a, d;
        chk({tag, "_rst_count"}, 32'(rst_idx_q.size() - rb), 32'd3);
        for (int k = 0; k < 3; k++) begin
            a = (rb + k < rst_idx_q.size())  ? 32'(rst_idx_q[rb + k]) : 'x;
            d = (rb + k < rst_data_q.size()) ? rst_data_q[rb + k] : 'x;
            chk({tag, "_rst_idx"},  a, 32'(EXP_IDX[k]));
            chk({tag, "_rst_data"}, d, EXP_VAL[k]);
        end
    endtask

    task automatic set_dirty3();
        bus.dirty_vals      = '0;
        bus.dirty_vals[0]   = 1'b1;
        bus.dirty_vals[1]   = 1'b1;
        bus.dirty_vals[3]   = 1'b1;   // reg 1 written but clean: must be skipped
        bus.dirty_vals[34]  = 1'b1;
        bus.dirty_vals[104] = 1'b1;
    endtask

    task automatic pulse_wake();
        wake = 1'b1;
        tick();
        wake = 1'b0;
    endtask

    // ---------------- directed sequence -------------------------------------
    initial begin
        int wb, bb, rb, g0;
        Rst = 1'b0; stand_by = 1'b0; Pwr_off = 1'b0; wake = 1'b0;
        bus.dirty_vals = '0;
        for (int i = 0; i < NREG; i++) bus.backup_Vouts[i*W +: W] = 32'h1000_0000 + 32'(i);
        bus.backup_Vouts[0*W +: W]  = EXP_VAL[0];
        bus.backup_Vouts[17*W +: W] = EXP_VAL[1];
        bus.backup_Vouts[52*W +: W] = EXP_VAL[2];
        repeat (3) tick();
        check_idle("reset");
        Rst = 1'b1;
        tick();

        // clean stand-by: SLEEP reached after NREG+2 cycles, no NV writes
        wb = wr_addr_q.size();
        stand_by = 1'b1;
        tick();
        chk("sby_halt", {31'b0, core_halt}, 32'd1);
        stand_by = 1'b0;
        repeat (53) tick();
        chk("sby_busy_before_sleep", {31'b0, busy}, 32'd1);
        tick();
        chk("sby_sleep_busy", {31'b0, busy}, 32'd0);
        chk("sby_sleep_halt", {31'b0, core_halt}, 32'd1);
        chk("sby_no_gate", {31'b0, pwr_gate}, 32'd0);
        chk("sby_no_writes", 32'(wr_addr_q.size() - wb), 32'd0);
        pulse_wake();
        chk("sby_wake_release", {31'b0, core_halt}, 32'd0);

        // power-off save/restore, fast NV
        set_dirty3();
        wb = wr_addr_q.size(); bb = bens_q.size(); rb = rst_idx_q.size();
        Pwr_off = 1'b1;
        tick();
        Pwr_off = 1'b0;
        wait_cond(0, 1000, "off_gate");
        chk("off_sleep_halt", {31'b0, core_halt}, 32'd1);
        check_saves(wb, bb, "off");
        pulse_wake();
        chk("off_ungated", {31'b0, pwr_gate}, 32'd0);
        wait_cond(1, 1000, "off_release");
        check_restores(rb, "off");

        // slow NV: 5-cycle ack latency, same results, stable request
        nv_dly = 5;
        wb = wr_addr_q.size(); bb = bens_q.size(); rb = rst_idx_q.size();
        Pwr_off = 1'b1;
        tick();
        Pwr_off = 1'b0;
        wait_cond(0, 2000, "slow_gate");
        check_saves(wb, bb, "slow");
        pulse_wake();
        wait_cond(1, 2000, "slow_release");
        check_restores(rb, "slow");
        chk("slow_stable", 32'(unstable), 32'd0);

        // priority: both requests together -> OFF mode; clean regs still restored
        nv_dly = 1;
        bus.dirty_vals = '0;
        wb = wr_addr_q.size(); rb = rst_idx_q.size();
        stand_by = 1'b1; Pwr_off = 1'b1;
        tick();
        stand_by = 1'b0; Pwr_off = 1'b0;
        wait_cond(0, 1000, "prio_gate");
        chk("prio_no_writes", 32'(wr_addr_q.size() - wb), 32'd0);
        pulse_wake();
        wait_cond(1, 1000, "prio_release");
        check_restores(rb, "prio");

        // early wake during save of reg 17: no gating, restore follows directly
        set_dirty3();
        wb = wr_addr_q.size(); bb = bens_q.size(); rb = rst_idx_q.size();
        g0 = gate_cycles;
        Pwr_off = 1'b1;
        tick();
        Pwr_off = 1'b0;
        wait_cond(2, 1000, "early_save17");
        pulse_wake();
        wait_cond(1, 2000, "early_release");
        chk("early_no_gate", 32'(gate_cycles - g0), 32'd0);
        check_saves(wb, bb, "early");
        check_restores(rb, "early");

        // reset in the middle of saving reg 17 wipes NV validity
        set_dirty3();
        Pwr_off = 1'b1;
        tick();
        Pwr_off = 1'b0;
        wait_cond(2, 1000, "rst_save17");
        Rst = 1'b0;
        tick();
        check_idle("midrst");
        Rst = 1'b1;
        bus.dirty_vals = '0;
        tick();
        wb = wr_addr_q.size(); rb = rst_idx_q.size();
        Pwr_off = 1'b1;
        tick();
        Pwr_off = 1'b0;
        wait_cond(0, 1000, "post_rst_gate");
        pulse_wake();
        wait_cond(1, 1000, "post_rst_release");
        chk("post_rst_no_writes",   32'(wr_addr_q.size() - wb), 32'd0);
        chk("post_rst_no_restores", 32'(rst_idx_q.size() - rb), 32'd0);

        // protocol invariants over the whole run
        chk("nv_we_re_exclusive", 32'(viol_both),   32'd0);
        chk("strobes_one_hot",    32'(viol_onehot), 32'd0);
        chk("restore_slices_zero", 32'(viol_slice), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
